led_matrix_pwm_driver: RTL



---
 rtl/led_matrix_pkg.sv | 16 +
 rtl/pin_sync_edge.sv | 38 +++
 rtl/led_matrix_pwm_driver.sv | 134 +++++++++++++
 3 files changed

// File: rtl/led_matrix_pkg.sv
// rtl/led_matrix_pkg.sv - shared constants and helpers for the LED matrix PWM driver
package led_matrix_pkg;

  localparam int SYNC_STAGES = 2;

  // Width of a counter that must hold 0..n-1 (never narrower than 1 bit).
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Bit offset of pixel (c, r) inside the shift chain / frame buffer.
  function automatic int pix_index(input int c, input int r, input int nrows, input int bpp);
    return (c * nrows + r) * bpp;
  endfunction

endpackage

// File: rtl/pin_sync_edge.sv
// rtl/pin_sync_edge.sv - 2-FF pin synchroniser with optional rising-edge pulse
module pin_sync_edge
  import led_matrix_pkg::*;
#(
  parameter bit EDGE_DETECT = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_pin,
  output logic o_sync,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;

  // Metastability chain: the pin enters at bit 0 and is used from the top bit.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_sync <= '0;
    else         r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
  end

  assign o_sync = r_sync[SYNC_STAGES-1];

  generate
    if (EDGE_DETECT) begin : g_edge
      logic r_prev;
      // Previous synced value, so a 0 -> 1 step yields a single-cycle pulse.
      always_ff @(posedge i_clk) begin
        if (i_reset) r_prev <= 1'b0;
        else         r_prev <= o_sync;
      end
      assign o_rise = o_sync & ~r_prev;
    end else begin : g_no_edge
      assign o_rise = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/led_matrix_pwm_driver.sv
// rtl/led_matrix_pwm_driver.sv - column-scan LED matrix driver with per-pixel PWM
module led_matrix_pwm_driver
  import led_matrix_pkg::*;
#(
  parameter int NROWS        = 8,
  parameter int NCOLS        = 8,
  parameter int BPP          = 2,
  parameter int COL_DWELL    = 18,
  parameter int BLANK_CYCLES = 2,
  parameter int SYNC_LATCH   = 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_din,
  input  logic             i_dclk,
  input  logic             i_strobe,
  output logic [NROWS-1:0] o_row_out,
  output logic [NCOLS-1:0] o_col_sel,
  output logic             o_frame_start,
  output logic             o_latch_pending
);

  localparam int W       = NROWS * NCOLS * BPP;
  localparam int PHASE_W = cnt_width(COL_DWELL);
  localparam int COL_W   = cnt_width(NCOLS);
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(COL_DWELL - 1);
  localparam logic [PHASE_W-1:0] BLANK_P    = PHASE_W'(BLANK_CYCLES);
  localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(NCOLS - 1);

  generate
    if (BLANK_CYCLES >= COL_DWELL) begin : g_chk_blank
      $error("BLANK_CYCLES must be less than COL_DWELL");
    end
    if (((COL_DWELL - BLANK_CYCLES) % (1 << BPP)) != 0) begin : g_chk_pwm
      $error("active part of the dwell must be a multiple of 2**BPP");
    end
    if (NCOLS < 2 || BPP < 1) begin : g_chk_size
      $error("need NCOLS >= 2 and BPP >= 1");
    end
  endgenerate

  logic w_din_s, w_din_rise;
  logic w_dclk_s, w_dclk_rise;
  logic w_strobe_s, w_strobe_rise;

  pin_sync_edge #(.EDGE_DETECT(1'b0)) u_sync_din (
    .i_clk(i_clk), .i_reset(i_reset), .i_pin(i_din), .o_sync(w_din_s), .o_rise(w_din_rise)
  );
  pin_sync_edge #(.EDGE_DETECT(1'b1)) u_sync_dclk (
    .i_clk(i_clk), .i_reset(i_reset), .i_pin(i_dclk), .o_sync(w_dclk_s), .o_rise(w_dclk_rise)
  );
  pin_sync_edge #(.EDGE_DETECT(1'b1)) u_sync_strobe (
    .i_clk(i_clk), .i_reset(i_reset), .i_pin(i_strobe), .o_sync(w_strobe_s), .o_rise(w_strobe_rise)
  );

  logic [W-1:0]       r_chain, r_fbuf;
  logic [PHASE_W-1:0] r_phase;
  logic [COL_W-1:0]   r_col;
  logic               r_latch_pending, r_frame_start;
  logic [NROWS-1:0]   r_row_out;
  logic [NCOLS-1:0]   r_col_sel;

  logic w_phase_wrap, w_boundary, w_do_latch;
  assign w_phase_wrap = (r_phase == PHASE_LAST);
  assign w_boundary   = w_phase_wrap && (r_col == COL_LAST);
  // Deferred mode copies only on the frame wrap so a frame is never mixed;
  // immediate mode copies the cycle after the request is registered.
  assign w_do_latch   = (SYNC_LATCH != 0) ? (w_boundary && (r_latch_pending || w_strobe_rise))
                                          : r_latch_pending;

  // Scan position: phase within the column dwell, then column.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_phase <= '0;
      r_col   <= '0;
    end else if (w_phase_wrap) begin
      r_phase <= '0;
      r_col   <= (r_col == COL_LAST) ? '0 : r_col + 1'b1;
    end else begin
      r_phase <= r_phase + 1'b1;
    end
  end

  // Serial shift chain, frame buffer copy and the pending-latch flag.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_chain         <= '0;
      r_fbuf          <= '0;
      r_latch_pending <= 1'b0;
    end else begin
      if (w_dclk_rise) r_chain <= {r_chain[W-2:0], w_din_s};
      if (w_do_latch)  r_fbuf  <= r_chain;
      r_latch_pending <= w_do_latch ? 1'b0 : (r_latch_pending | w_strobe_rise);
    end
  end

  logic [PHASE_W-1:0] w_active;
  logic [BPP-1:0]     w_q;
  logic [NROWS-1:0]   w_row_next;
  logic [NCOLS-1:0]   w_col_next;

  // Drive for the current scan position: blanked lead-in, then PWM compare.
  always_comb begin
    w_row_next = '0;
    w_col_next = '0;
    w_active   = r_phase - BLANK_P;
    w_q        = w_active[BPP-1:0];
    if (r_phase >= BLANK_P) begin
      w_col_next[r_col] = 1'b1;
      for (int r = 0; r < NROWS; r++) begin
        w_row_next[r] = (r_fbuf[pix_index(int'(r_col), r, NROWS, BPP) +: BPP] > w_q);
      end
    end
  end

  // Registered pin drive and frame marker, one clock behind the counters.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_row_out     <= '0;
      r_col_sel     <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_row_out     <= w_row_next;
      r_col_sel     <= w_col_next;
      r_frame_start <= w_boundary;
    end
  end

  assign o_row_out       = r_row_out;
  assign o_col_sel       = r_col_sel;
  assign o_frame_start   = r_frame_start;
  assign o_latch_pending = r_latch_pending;

endmodule
